// File: rtl/tt_um_jimktrains_vslc_delay_arb_if.sv
// Handshake bundle between the VSLC requesters, the delay arbiter and the shared timer.
// The arbiter connects through the slave modport; requesters and the timer sit on the master side.
interface tt_um_jimktrains_vslc_delay_arb_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] period;
   logic [N_REQ-1:0]       gnt;
   logic [N_REQ-1:0]       done;
   logic                   busy;
   logic [WIDTH-1:0]       timer_period;
   logic                   timer_enabled;
   logic                   timer_output;

   modport master (
      output req, period, timer_output,
      input  gnt, done, busy, timer_period, timer_enabled
   );

   modport slave (
      input  req, period, timer_output,
      output gnt, done, busy, timer_period, timer_enabled
   );
endinterface

// File: rtl/tt_um_jimktrains_vslc_delay_arb.sv
// Shares one VSLC square-wave timer among N_REQ one-shot delay requesters (IDLE -> RUN -> DONE).
// Define VSLC_DELAY_ARB_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module tt_um_jimktrains_vslc_delay_arb #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8
) (
   input logic clk,
   input logic rst,
   tt_um_jimktrains_vslc_delay_arb_if.slave bus
);
   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q;
   logic [N_REQ-1:0] gnt_q;
   logic [N_REQ-1:0] done_q;
   logic             busy_q;
   logic             en_q;
   logic [WIDTH-1:0] period_q;
   logic [IDX_W-1:0] idx_q;

   logic             win_vld_c;
   logic [IDX_W-1:0] win_idx_c;

`ifdef VSLC_DELAY_ARB_PRIO_EN
   // Lowest index wins: scan downward so the last hit is the smallest index.
   always_comb begin
      win_vld_c = 1'b0;
      win_idx_c = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (bus.req[IDX_W'(i)]) begin
            win_vld_c = 1'b1;
            win_idx_c = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W-1:0] last_q;

   // First requester after last_q modulo N_REQ; scan offsets downward so the nearest wins.
   always_comb begin
      win_vld_c = 1'b0;
      win_idx_c = '0;
      for (int off = int'(N_REQ); off >= 1; off--) begin
         if (bus.req[IDX_W'((int'(last_q) + off) % int'(N_REQ))]) begin
            win_vld_c = 1'b1;
            win_idx_c = IDX_W'((int'(last_q) + off) % int'(N_REQ));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= IDX_W'(N_REQ - 1);
      end else if (state_q == IDLE && win_vld_c) begin
         last_q <= win_idx_c;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         en_q     <= 1'b0;
         period_q <= '0;
         idx_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_vld_c) begin
                  gnt_q    <= N_REQ'(1) << win_idx_c;
                  period_q <= bus.period[win_idx_c*WIDTH +: WIDTH];
                  en_q     <= 1'b1;
                  busy_q   <= 1'b1;
                  idx_q    <= win_idx_c;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               // A dropped request aborts silently and wins over a same-edge completion.
               if (!bus.req[idx_q]) begin
                  gnt_q   <= '0;
                  en_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (bus.timer_output) begin
                  en_q    <= 1'b0;
                  done_q  <= gnt_q;
                  gnt_q   <= '0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               // One disabled cycle lets the timer drop its output before the next grant.
               done_q  <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt           = gnt_q;
   assign bus.done          = done_q;
   assign bus.busy          = busy_q;
   assign bus.timer_period  = period_q;
   assign bus.timer_enabled = en_q;
endmodule

// File: tb/tb_tt_um_jimktrains_vslc_delay_arb.sv
// Bench for the VSLC delay arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-timing model (grant, done at grant+P+2, next grant no earlier than grant+P+4).
module tb_tt_um_jimktrains_vslc_delay_arb;
   localparam int unsigned N_REQ = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned IW    = $clog2(N_REQ);

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] per [N_REQ];
   logic [WIDTH-1:0] tcnt;
   logic             tout;
   int               checks = 0;
   int               errors = 0;

   int               m_k, m_owner, m_g, m_p, m_free, m_last;
   logic [N_REQ-1:0] exp_gnt, exp_done, prev_gnt;
   logic             exp_busy, exp_en;
   logic [WIDTH-1:0] exp_tp;
   int               gk[$];
   int               gi[$];
   int               n;

   always #5 clk = ~clk;

   tt_um_jimktrains_vslc_delay_arb_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

   tt_um_jimktrains_vslc_delay_arb #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always_comb begin
      for (int i = 0; i < int'(N_REQ); i++) bus.period[i*WIDTH +: WIDTH] = per[IW'(i)];
   end

   // Companion timer: output rises P edges after it first sees enable, low while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
         tout <= 1'b0;
      end else if (!bus.timer_enabled) begin
         tcnt <= '0;
         tout <= 1'b0;
      end else if (tcnt == bus.timer_period) begin
         tout <= 1'b1;
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end
   assign bus.timer_output = tout & bus.timer_enabled;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, m_k, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_k = 0; m_owner = -1; m_g = 0; m_p = 0; m_free = 0; m_last = N_REQ - 1;
      exp_gnt = '0; exp_done = '0; exp_busy = 1'b0; exp_en = 1'b0; exp_tp = '0;
      prev_gnt = '0;
   endtask

   function automatic int pick(input logic [N_REQ-1:0] r);
      int w = -1;
`ifdef VSLC_DELAY_ARB_PRIO_EN
      for (int i = int'(N_REQ) - 1; i >= 0; i--)
         if (r[IW'(i)]) w = i;
`else
      for (int off = int'(N_REQ); off >= 1; off--)
         if (r[IW'((m_last + off) % int'(N_REQ))]) w = (m_last + off) % int'(N_REQ);
`endif
      return w;
   endfunction

   task automatic check_outputs(input string sfx);
      check({"gnt", sfx},  32'(bus.gnt),           32'(exp_gnt));
      check({"done", sfx}, 32'(bus.done),          32'(exp_done));
      check({"busy", sfx}, 32'(bus.busy),          32'(exp_busy));
      check({"tper", sfx}, 32'(bus.timer_period),  32'(exp_tp));
      check({"ten", sfx},  32'(bus.timer_enabled), 32'(exp_en));
   endtask

   // Advance one edge: predict from the inputs the DUT is about to sample, then compare.
   task automatic step();
      logic [N_REQ-1:0] r;
      logic             own_req;
      int               w;
      r = bus.req;
      m_k++;
      exp_done = '0;
      own_req = (m_owner >= 0) && ((r & (N_REQ'(1) << m_owner)) != '0);
      if (m_owner >= 0 && !own_req) begin
         exp_gnt = '0; exp_en = 1'b0; exp_busy = 1'b0;
         m_owner = -1; m_free = m_k + 1;
      end else if (m_owner >= 0 && m_k == m_g + m_p + 2) begin
         exp_done = N_REQ'(1) << m_owner;
         exp_gnt = '0; exp_en = 1'b0;
         m_owner = -1; m_free = m_k + 2;
      end else if (m_owner < 0 && m_k >= m_free && r != '0) begin
         w = pick(r);
         m_owner = w; m_g = m_k; m_p = int'(per[IW'(w)]); m_last = w;
         exp_gnt = N_REQ'(1) << w; exp_en = 1'b1; exp_busy = 1'b1; exp_tp = per[IW'(w)];
      end else if (m_owner < 0) begin
         exp_busy = 1'b0;
      end
      @(posedge clk);
      #1;
      check_outputs("");
      if (bus.gnt != '0 && prev_gnt == '0) begin
         for (int i = 0; i < int'(N_REQ); i++) if (bus.gnt[IW'(i)]) gi.push_back(i);
         gk.push_back(m_k);
      end
      prev_gnt = bus.gnt;
   endtask

   task automatic run_until_done(input int bound, output int cnt);
      cnt = 0;
      while (bus.done == '0 && cnt < bound) begin
         step();
         cnt++;
      end
      check("done_seen", 32'(|bus.done), 32'd1);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs("_rst");
      check("tout_rst", 32'(bus.timer_output), 32'd0);
      #2;
      rst = 1'b0;
   endtask

   task automatic idle(input int cycles);
      bus.req = '0;
      repeat (cycles) step();
   endtask

   initial begin
      rst = 1'b1;
      bus.req = '0;
      for (int i = 0; i < int'(N_REQ); i++) per[IW'(i)] = '0;
      model_reset();
      #12;
      check_outputs("_por");
      rst = 1'b0;

      // single request, P=5: done exactly 7 edges after the grant
      per[0] = 8'd5; bus.req = 4'b0001;
      step();
      check("t1_gnt", 32'(bus.gnt), 32'h1);
      run_until_done(40, n);
      check("t1_done_edge", 32'(n), 32'd7);
      check("t1_done", 32'(bus.done), 32'h1);
      check("t1_ten", 32'(bus.timer_enabled), 32'd0);
      idle(3);

      // period zero
      per[2] = 8'd0; bus.req = 4'b0100;
      step();
      run_until_done(40, n);
      check("t2_done_edge", 32'(n), 32'd2);
      check("t2_done", 32'(bus.done), 32'h4);
      bus.req = '0;
      repeat (3) begin
         step();
         check("t2_tout_quiet", 32'(bus.timer_output), 32'd0);
      end

      // round-robin fairness with all requests held
      reset_pulse();
      for (int i = 0; i < int'(N_REQ); i++) per[IW'(i)] = 8'd1;
      gi.delete(); gk.delete();
      bus.req = 4'b1111;
      repeat (22) step();
      check("t3_ngrants", 32'(gi.size()), 32'd5);
      for (int j = 0; j < 5 && j < gi.size(); j++) begin
`ifdef VSLC_DELAY_ARB_PRIO_EN
         check("t3_order", 32'(gi[j]), 32'd0);
`else
         check("t3_order", 32'(gi[j]), 32'(j % 4));
`endif
         if (j > 0) check("t3_gap", 32'(gk[j] - gk[j-1]), 32'd5);
      end
      idle(4);

      // abort: drop req[1] mid-run, pending req[3] follows
      per[1] = 8'd20; per[3] = 8'd2;
      bus.req = 4'b0010;
      step();
      check("t4_gnt1", 32'(bus.gnt), 32'h2);
      bus.req = 4'b1010;
      repeat (6) step();
      bus.req = 4'b1000;
      step();
      check("t4_abort_gnt", 32'(bus.gnt), 32'h0);
      check("t4_abort_ten", 32'(bus.timer_enabled), 32'd0);
      step();
      check("t4_gnt3", 32'(bus.gnt), 32'h8);
      run_until_done(40, n);
      check("t4_done_edge", 32'(n), 32'd4);
      check("t4_done", 32'(bus.done), 32'h8);
      idle(3);

      // period change during RUN is ignored
      per[0] = 8'd5; bus.req = 4'b0001;
      step();
      per[0] = 8'd9;
      run_until_done(40, n);
      check("t5_done_edge", 32'(n), 32'd7);
      check("t5_tper", 32'(bus.timer_period), 32'd5);
      idle(3);

      // asynchronous reset three cycles into a P=10 delay
      per[0] = 8'd10; bus.req = 4'b0001;
      step();
      repeat (3) step();
      reset_pulse();
      step();
      check("t6_regnt", 32'(bus.gnt), 32'h1);
      run_until_done(40, n);
      check("t6_done_edge", 32'(n), 32'd12);
      idle(3);

      // random traffic: requests held until done, occasional aborts and period churn
      repeat (800) begin
         for (int i = 0; i < int'(N_REQ); i++) begin
            if (bus.done[IW'(i)]) begin
               if ($urandom_range(0, 1) == 1) bus.req[IW'(i)] = 1'b0;
            end else if (!bus.req[IW'(i)]) begin
               if ($urandom_range(0, 3) == 0) begin
                  bus.req[IW'(i)] = 1'b1;
                  per[IW'(i)] = WIDTH'($urandom_range(0, 6));
               end
            end else if ($urandom_range(0, 63) == 0) begin
               bus.req[IW'(i)] = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
               per[IW'(i)] = WIDTH'($urandom_range(0, 15));
            end
         end
         step();
      end
      idle(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
